exp_pulse_gen: RTL and testbench
================================

// Module: exp_pulse_gen
// PURPOSE
//  Synthesises 14-bit signed detector-preamp pulses: a linear rise followed by an
//  exponential tail, with the decay factor matched to the delta stage (0.985, Q16 64553).
//  Acts as the signal source for the stage-1 delta block, so a generated tail is cancelled there.
//  Used as a bench/BIST source in front of the trapezoidal filter chain.
//  Supports pile-up: a trigger during a pulse superimposes a new pulse on it.
// PARAMETERS
//  DECAY_COEF  64553  tail multiplier per cycle, unsigned Q0.16 (0.985*2^16)
//  RISE_SHIFT  2      rise length = 2^RISE_SHIFT cycles
//  TAIL_LEN    1024   number of DECAY cycles before the pulse ends (>=2)
//  BASELINE    0      signed 14-bit offset added to every output sample
// PORTS
//  SYS_CLK     in   1   clock, rising edge
//  RESET_N     in   1   asynchronous active-low reset
//  ENABLE      in   1   trigger qualifier; TRIG is ignored while low
//  TRIG        in   1   pulse request, sampled on every rising edge
//  AMPL        in   14  signed pulse amplitude, sampled with TRIG
//  DATA        out  14  signed registered sample output (feeds DATA of stage 1)
//  BUSY        out  1   registered, high while state != IDLE
//  PULSE_DONE  out  1   1-cycle strobe on the edge that returns the FSM to IDLE
//  PILEUP      out  1   1-cycle strobe when a trigger is accepted outside IDLE
// BEHAVIOUR
//  Reset (async, RESET_N=0): state=IDLE, ACC=0, cnt=0, DATA=sat14(BASELINE),
//   BUSY=0, PULSE_DONE=0, PILEUP=0. Reset mid-pulse aborts the pulse; no DONE strobe.
//  ACC: signed 32-bit, Q16 (sample value << 16). STEP: signed 32-bit = (AMPL<<16)>>>RISE_SHIFT.
//  Every edge: DATA <= sat14(BASELINE + (ACC_next>>>16)), i.e. DATA shows the value written to ACC
//   on the same edge. sat14 clamps to [-8192, 8191]. ACC itself never saturates.
//  FSM:
//   IDLE : ACC held at 0. TRIG&ENABLE -> latch STEP, cnt=0, go RISE.
//          No ACC change on this edge.
//   RISE : ACC += STEP; cnt++; after 2^RISE_SHIFT RISE edges -> DECAY, cnt=0.
//   DECAY: ACC = (ACC*DECAY_COEF)>>>16, 48-bit signed product, floor via arithmetic shift.
//          cnt++; on the edge with cnt==TAIL_LEN-1 -> IDLE, ACC=0, PULSE_DONE=1.
//  Latency: TRIG sampled at edge k -> first rise sample on DATA after edge k+1,
//   peak after edge k+2^RISE_SHIFT, first decay sample after edge k+2^RISE_SHIFT+1.
//  Pile-up: TRIG&ENABLE in RISE or DECAY -> PILEUP=1, latch new STEP, cnt=0, go RISE.
//   ACC is not modified on that edge. The new rise adds onto the current ACC (superposition).
//  TRIG on the final DECAY edge: the trigger wins; pile-up path taken, no PULSE_DONE, ACC kept.
//  ENABLE low: TRIG ignored in every state; a running pulse completes normally.
//  AMPL=0 or negative: legal. Full pulse timing applies, DONE is asserted, negative tail.
//  BUSY updates on the same edge as the state register.
// TESTING
//  1 Reset: BASELINE=0, RESET_N=0 -> DATA=0, BUSY=0. Release, idle 10 cycles -> DATA stays 0.
//  2 Single pulse: AMPL=4096, TRIG 1 cycle -> DATA 1024,2048,3072,4096, then 4034, 3974.
//    PULSE_DONE exactly 1028 edges after the rise starts; BUSY falls on the same edge.
//  3 Round trip: feed DATA into stage-1 delta block -> rise outputs >= 1,000,000,
//    every DECAY-phase output |DATAOUT| < 2048.
//  4 Pile-up: AMPL=4096, second TRIG AMPL=2048 on 10th DECAY edge -> PILEUP 1 cycle, cnt restarts.
//    Next 4 samples = prev + 512*i (floor), then decay; single PULSE_DONE at the end.
//  5 Saturation/sign: BASELINE=1000, AMPL=8191 -> DATA clamps at 8191.
//    BASELINE=0, AMPL=-8192 -> rise to -8192, negative tail, no wrap.
//  6 ENABLE=0 with TRIG pulses -> no pulse. Async RESET_N low mid-DECAY -> immediate IDLE,
//    DATA=BASELINE, no PULSE_DONE. TRIG on final DECAY edge -> PILEUP, no PULSE_DONE.

Source files
------------

// File: rtl/exp_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : exp_pulse_gen
// Brief    : Detector-preamp pulse source: linear rise, exponential tail,
//            with pile-up by superposition of a new rise onto the running ACC.
// Revision : 1.0 - initial release
// ============================================================================
module exp_pulse_gen #(
  parameter int unsigned DECAY_COEF = 64553,
  parameter int unsigned RISE_SHIFT = 2,
  parameter int unsigned TAIL_LEN   = 1024,
  parameter int          BASELINE   = 0
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        TRIG,
  input  logic [13:0] AMPL,
  output logic [13:0] DATA,
  output logic        BUSY,
  output logic        PULSE_DONE,
  output logic        PILEUP
);

  function automatic logic [13:0] sat14(input logic signed [17:0] v);
    if (v > 18'sd8191) begin
      sat14 = 14'h1FFF;
    end else if (v < -18'sd8192) begin
      sat14 = 14'h2000;
    end else begin
      sat14 = v[13:0];
    end
  endfunction

  localparam int                 c_RISE_LEN = 1 << RISE_SHIFT;
  localparam int                 c_CNT_MAX  = (TAIL_LEN > c_RISE_LEN) ? TAIL_LEN : c_RISE_LEN;
  localparam int                 c_CNT_W    = $clog2(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_RISE_LAST = c_CNT_W'(c_RISE_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_TAIL_LAST = c_CNT_W'(TAIL_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [15:0]        c_COEF      = 16'(DECAY_COEF);
  localparam logic signed [17:0] c_BASE      = 18'(BASELINE);
  localparam logic [13:0]        c_DATA_RST  = sat14(c_BASE);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RISE  = 2'd1;
  localparam logic [1:0] c_DECAY = 2'd2;

  logic [1:0]         r_state;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_step;
  logic [c_CNT_W-1:0] r_cnt;

  logic [1:0]         w_state_next;
  logic signed [31:0] w_acc_next;
  logic signed [31:0] w_step_next;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               w_done_next;
  logic               w_pileup_next;
  logic               w_trig;
  logic signed [31:0] w_step_new;
  logic signed [47:0] w_prod;
  logic signed [31:0] w_decayed;
  logic signed [17:0] w_sum;
  logic [13:0]        w_data_next;
  logic               w_unused;

  assign w_trig     = TRIG & ENABLE;
  assign w_step_new = $signed({{2{AMPL[13]}}, AMPL, 16'h0000}) >>> RISE_SHIFT;

  // Coefficient is below 1.0, so the shifted product always fits back into 32 bits.
  assign w_prod    = 48'(r_acc) * 48'($signed({1'b0, c_COEF}));
  assign w_decayed = w_prod[47:16];
  assign w_unused  = ^w_prod[15:0];

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_step_next   = r_step;
    w_cnt_next    = r_cnt;
    w_done_next   = 1'b0;
    w_pileup_next = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_acc_next = '0;
        if (w_trig) begin
          w_step_next  = w_step_new;
          w_cnt_next   = '0;
          w_state_next = c_RISE;
        end
      end
      c_RISE: begin
        if (w_trig) begin
          w_pileup_next = 1'b1;
          w_step_next   = w_step_new;
          w_cnt_next    = '0;
        end else begin
          w_acc_next = r_acc + r_step;
          if (r_cnt == c_RISE_LAST) begin
            w_cnt_next   = '0;
            w_state_next = c_DECAY;
          end else begin
            w_cnt_next = r_cnt + c_CNT_ONE;
          end
        end
      end
      c_DECAY: begin
        // A trigger on the final tail edge takes priority over ending the pulse.
        if (w_trig) begin
          w_pileup_next = 1'b1;
          w_step_next   = w_step_new;
          w_cnt_next    = '0;
          w_state_next  = c_RISE;
        end else if (r_cnt == c_TAIL_LAST) begin
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
          w_state_next = c_IDLE;
        end else begin
          w_acc_next = w_decayed;
          w_cnt_next = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_acc_next   = '0;
        w_cnt_next   = '0;
        w_state_next = c_IDLE;
      end
    endcase
  end

  assign w_sum       = c_BASE + {{2{w_acc_next[31]}}, w_acc_next[31:16]};
  assign w_data_next = sat14(w_sum);

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= c_IDLE;
      r_acc      <= '0;
      r_step     <= '0;
      r_cnt      <= '0;
      DATA       <= c_DATA_RST;
      BUSY       <= 1'b0;
      PULSE_DONE <= 1'b0;
      PILEUP     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_step     <= w_step_next;
      r_cnt      <= w_cnt_next;
      DATA       <= w_data_next;
      BUSY       <= (w_state_next != c_IDLE);
      PULSE_DONE <= w_done_next;
      PILEUP     <= w_pileup_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exp_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_pulse_gen
// Brief    : Directed bench for exp_pulse_gen (BASELINE=0 and BASELINE=1000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_pulse_gen;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        en_a, trig_a, en_b, trig_b;
  logic [13:0] ampl_a, ampl_b;
  logic [13:0] data_a, data_b;
  logic        busy_a, done_a, pile_a, busy_b, done_b, pile_b;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 sys_clk = ~sys_clk;

  exp_pulse_gen dut_a (
    .SYS_CLK(sys_clk), .RESET_N(reset_n), .ENABLE(en_a), .TRIG(trig_a), .AMPL(ampl_a),
    .DATA(data_a), .BUSY(busy_a), .PULSE_DONE(done_a), .PILEUP(pile_a)
  );

  exp_pulse_gen #(.BASELINE(1000)) dut_b (
    .SYS_CLK(sys_clk), .RESET_N(reset_n), .ENABLE(en_b), .TRIG(trig_b), .AMPL(ampl_b),
    .DATA(data_b), .BUSY(busy_b), .PULSE_DONE(done_b), .PILEUP(pile_b)
  );

  function automatic longint decay(input longint acc);
    return (acc * 64553) >>> 16;
  endfunction

  function automatic logic [13:0] to_data(input longint acc, input int base);
    longint v;
    v = (acc >>> 16) + base;
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v[13:0];
  endfunction

  task automatic start_a(input logic [13:0] ampl);
    @(negedge sys_clk); en_a = 1'b1; ampl_a = ampl; trig_a = 1'b1;
    @(negedge sys_clk); trig_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en_a = 0; trig_a = 0; ampl_a = '0; en_b = 0; trig_b = 0; ampl_b = '0;
    #12;
    n_total++; if (data_a !== 14'd0 || busy_a !== 1'b0) $display("FAIL reset_a: DATA=%0d BUSY=%b expected 0 0", $signed(data_a), busy_a); else n_pass++;
    n_total++; if (data_b !== 14'd1000 || busy_b !== 1'b0) $display("FAIL reset_b: DATA=%0d BUSY=%b expected 1000 0", $signed(data_b), busy_b); else n_pass++;
    n_total++; if (done_a !== 1'b0 || pile_a !== 1'b0) $display("FAIL reset_strobes: DONE=%b PILEUP=%b expected 0 0", done_a, pile_a); else n_pass++;
    @(negedge sys_clk); reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      n_total++; if (data_a !== 14'd0 || busy_a !== 1'b0) $display("FAIL reset_idle[%0d]: DATA=%0d BUSY=%b expected 0 0", i, $signed(data_a), busy_a); else n_pass++;
    end
  endtask

  task automatic test_single_pulse();
    int n;
    logic [13:0] exp;
    start_a(14'd4096);
    n_total++; if (data_a !== 14'd0 || busy_a !== 1'b1) $display("FAIL pulse_start: DATA=%0d BUSY=%b expected 0 1", $signed(data_a), busy_a); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk); exp = 14'(1024 * i);
      n_total++; if (data_a !== exp) $display("FAIL pulse_rise[%0d]: DATA=%0d expected %0d", i, $signed(data_a), $signed(exp)); else n_pass++;
    end
    @(negedge sys_clk);
    n_total++; if (data_a !== 14'd4034) $display("FAIL pulse_decay1: DATA=%0d expected 4034", $signed(data_a)); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (data_a !== 14'd3974) $display("FAIL pulse_decay2: DATA=%0d expected 3974", $signed(data_a)); else n_pass++;
    n = 6;
    while (done_a !== 1'b1 && n < 1100) begin @(negedge sys_clk); n++; end
    n_total++; if (n != 1028) $display("FAIL pulse_done_edge: edge=%0d expected 1028", n); else n_pass++;
    n_total++; if (busy_a !== 1'b0 || data_a !== 14'd0) $display("FAIL pulse_end: BUSY=%b DATA=%0d expected 0 0", busy_a, $signed(data_a)); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (done_a !== 1'b0) $display("FAIL pulse_done_width: DONE=%b expected 0", done_a); else n_pass++;
  endtask

  task automatic test_pileup();
    longint acc;
    int ndone, first;
    logic [13:0] exp;
    start_a(14'd4096);
    acc = 0;
    repeat (4) begin @(negedge sys_clk); acc += 67108864; end
    repeat (9) begin @(negedge sys_clk); acc = decay(acc); end
    exp = to_data(acc, 0);
    n_total++; if (data_a !== exp) $display("FAIL pile_pre: DATA=%0d expected %0d", $signed(data_a), $signed(exp)); else n_pass++;
    ampl_a = 14'd2048; trig_a = 1'b1;
    @(negedge sys_clk); trig_a = 1'b0;
    n_total++; if (pile_a !== 1'b1 || busy_a !== 1'b1) $display("FAIL pile_strobe: PILEUP=%b BUSY=%b expected 1 1", pile_a, busy_a); else n_pass++;
    n_total++; if (data_a !== exp) $display("FAIL pile_hold: DATA=%0d expected %0d", $signed(data_a), $signed(exp)); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk); acc += 33554432; exp = to_data(acc, 0);
      n_total++; if (data_a !== exp) $display("FAIL pile_rise[%0d]: DATA=%0d expected %0d", i, $signed(data_a), $signed(exp)); else n_pass++;
      if (i == 1) begin
        n_total++; if (pile_a !== 1'b0) $display("FAIL pile_width: PILEUP=%b expected 0", pile_a); else n_pass++;
      end
    end
    @(negedge sys_clk); acc = decay(acc); exp = to_data(acc, 0);
    n_total++; if (data_a !== exp) $display("FAIL pile_decay: DATA=%0d expected %0d", $signed(data_a), $signed(exp)); else n_pass++;
    ndone = 0; first = 0;
    for (int n = 20; n <= 1100; n++) begin
      @(negedge sys_clk);
      if (done_a === 1'b1) begin ndone++; if (first == 0) first = n; end
    end
    n_total++; if (ndone != 1 || first != 1042) $display("FAIL pile_done: count=%0d edge=%0d expected 1 1042", ndone, first); else n_pass++;
  endtask

  task automatic test_saturation();
    int exp_a[5] = '{-2048, -4096, -6144, -8192, -8070};
    int exp_b[5] = '{3047, 5095, 7143, 8191, 8191};
    longint acc;
    int n;
    logic [13:0] prev, exp;
    @(negedge sys_clk);
    en_a = 1; ampl_a = 14'h2000; trig_a = 1; en_b = 1; ampl_b = 14'd8191; trig_b = 1;
    @(negedge sys_clk); trig_a = 0; trig_b = 0;
    n_total++; if (data_b !== 14'd1000) $display("FAIL sat_start_b: DATA=%0d expected 1000", $signed(data_b)); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      exp = 14'(exp_b[i]);
      n_total++; if (data_b !== exp) $display("FAIL sat_b[%0d]: DATA=%0d expected %0d", i, $signed(data_b), exp_b[i]); else n_pass++;
      exp = 14'(exp_a[i]);
      n_total++; if (data_a !== exp) $display("FAIL neg_a[%0d]: DATA=%0d expected %0d", i, $signed(data_a), exp_a[i]); else n_pass++;
    end
    acc = -536870912;
    for (int j = 1; j <= 1023; j++) acc = decay(acc);
    n = 5; prev = data_a;
    while (done_a !== 1'b1 && n < 1100) begin prev = data_a; @(negedge sys_clk); n++; end
    exp = to_data(acc, 0);
    n_total++; if (prev !== exp) $display("FAIL neg_tail_last: DATA=%0d expected %0d", $signed(prev), $signed(exp)); else n_pass++;
    n_total++; if (n != 1028 || done_b !== 1'b1) $display("FAIL sat_done: edge=%0d DONE_B=%b expected 1028 1", n, done_b); else n_pass++;
  endtask

  task automatic test_enable();
    logic bad;
    int n;
    en_a = 1'b0; bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (busy_a !== 1'b0 || data_a !== 14'd0 || pile_a !== 1'b0) bad = 1'b1;
      ampl_a = 14'd4096; trig_a = (i % 2 == 0);
    end
    n_total++; if (bad !== 1'b0) $display("FAIL enable_low_idle: activity=%b expected 0", bad); else n_pass++;
    trig_a = 1'b0;
    start_a(14'd4096);
    repeat (19) @(negedge sys_clk);
    en_a = 1'b0; trig_a = 1'b1;
    @(negedge sys_clk);
    n = 20;
    n_total++; if (pile_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL enable_low_pileup: PILEUP=%b BUSY=%b expected 0 1", pile_a, busy_a); else n_pass++;
    while (done_a !== 1'b1 && n < 1100) begin @(negedge sys_clk); n++; end
    n_total++; if (n != 1028) $display("FAIL enable_low_done: edge=%0d expected 1028", n); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (busy_a !== 1'b0) $display("FAIL enable_low_retrig: BUSY=%b expected 0", busy_a); else n_pass++;
    trig_a = 1'b0; en_a = 1'b1;
  endtask

  task automatic test_async_reset();
    logic saw_done, saw_busy;
    @(negedge sys_clk); en_b = 1; ampl_b = 14'd4096; trig_b = 1;
    @(negedge sys_clk); trig_b = 0;
    repeat (20) @(negedge sys_clk);
    n_total++; if (busy_b !== 1'b1) $display("FAIL areset_pre: BUSY=%b expected 1", busy_b); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (data_b !== 14'd1000 || busy_b !== 1'b0 || done_b !== 1'b0) $display("FAIL areset_now: DATA=%0d BUSY=%b DONE=%b expected 1000 0 0", $signed(data_b), busy_b, done_b); else n_pass++;
    @(negedge sys_clk); reset_n = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (1100) begin
      @(negedge sys_clk);
      if (done_b === 1'b1) saw_done = 1'b1;
      if (busy_b === 1'b1) saw_busy = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0 || saw_busy !== 1'b0) $display("FAIL areset_after: DONE_seen=%b BUSY_seen=%b expected 0 0", saw_done, saw_busy); else n_pass++;
    n_total++; if (data_b !== 14'd1000) $display("FAIL areset_baseline: DATA=%0d expected 1000", $signed(data_b)); else n_pass++;
  endtask

  task automatic test_trig_final();
    longint acc;
    int ndone, first;
    logic [13:0] exp;
    start_a(14'd4096);
    acc = 0;
    repeat (4) begin @(negedge sys_clk); acc += 67108864; end
    repeat (1023) begin @(negedge sys_clk); acc = decay(acc); end
    exp = to_data(acc, 0);
    n_total++; if (data_a !== exp || busy_a !== 1'b1) $display("FAIL final_pre: DATA=%0d BUSY=%b expected %0d 1", $signed(data_a), busy_a, $signed(exp)); else n_pass++;
    ampl_a = 14'd4096; trig_a = 1'b1;
    @(negedge sys_clk); trig_a = 1'b0;
    n_total++; if (pile_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL final_pileup: PILEUP=%b DONE=%b BUSY=%b expected 1 0 1", pile_a, done_a, busy_a); else n_pass++;
    n_total++; if (data_a !== exp) $display("FAIL final_hold: DATA=%0d expected %0d", $signed(data_a), $signed(exp)); else n_pass++;
    @(negedge sys_clk); acc += 67108864; exp = to_data(acc, 0);
    n_total++; if (data_a !== exp) $display("FAIL final_rerise: DATA=%0d expected %0d", $signed(data_a), $signed(exp)); else n_pass++;
    ndone = 0; first = 0;
    for (int n = 2; n <= 1100; n++) begin
      @(negedge sys_clk);
      if (done_a === 1'b1) begin ndone++; if (first == 0) first = n; end
    end
    n_total++; if (ndone != 1 || first != 1028) $display("FAIL final_done: count=%0d edge=%0d expected 1 1028", ndone, first); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_pileup();
    test_saturation();
    test_enable();
    test_async_reset();
    test_trig_final();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
